// File: rtl/demux_1x4_pkg.sv
// ============================================================================
// Module      : demux_1x4_pkg
// Description : Shared phy_rx constants and state encoding for the 1:4 lane demux.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package demux_1x4_pkg;

   localparam int LANES              = 4;
   localparam int PTR_W              = 2;
   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/demux_1x4_if.sv
// ============================================================================
// Module      : demux_1x4_if
// Description : Serial lane input and parallel frame output bundle of the demux.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface demux_1x4_if
   import demux_1x4_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_out0;
   logic [DATA_WIDTH-1:0] data_out1;
   logic [DATA_WIDTH-1:0] data_out2;
   logic [DATA_WIDTH-1:0] data_out3;
   logic                  valid_out0;
   logic                  valid_out1;
   logic                  valid_out2;
   logic                  valid_out3;
   logic                  frame_pulse;
   logic                  aligned;

   modport master (
      output data_in, valid_in,
      input  data_out0, data_out1, data_out2, data_out3,
      input  valid_out0, valid_out1, valid_out2, valid_out3,
      input  frame_pulse, aligned
   );

   modport slave (
      input  data_in, valid_in,
      output data_out0, data_out1, data_out2, data_out3,
      output valid_out0, valid_out1, valid_out2, valid_out3,
      output frame_pulse, aligned
   );

endinterface

`default_nettype wire

// File: rtl/demux_1x4.sv
// ============================================================================
// Module      : demux_1x4
// Description : Gathers a clk_4f byte-lane stream into 4-lane frames, published once per frame.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module demux_1x4
   import demux_1x4_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic        clk_4f,
   input  logic        reset,
   demux_1x4_if.slave  bus
);

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [DATA_WIDTH-1:0] lane_buf_q [LANES];
   logic [DATA_WIDTH-1:0] lane_buf_d [LANES];
   logic                  lane_vld_q [LANES];
   logic                  lane_vld_d [LANES];
   logic [DATA_WIDTH-1:0] data_out_q [LANES];
   logic [DATA_WIDTH-1:0] data_out_d [LANES];
   logic                  valid_out_q [LANES];
   logic                  valid_out_d [LANES];
   logic                  frame_pulse_q, frame_pulse_d;
   logic                  aligned_q, aligned_d;

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      lane_buf_d    = lane_buf_q;
      lane_vld_d    = lane_vld_q;
      data_out_d    = data_out_q;
      valid_out_d   = valid_out_q;
      frame_pulse_d = 1'b0;
      aligned_d     = aligned_q;

      case (state_q)
         IDLE: begin
            // First valid beat after idle defines lane 0 of a new frame.
            if (bus.valid_in) begin
               lane_buf_d[0] = bus.data_in;
               lane_vld_d[0] = 1'b1;
               ptr_d         = PTR_W'(1);
               state_d       = RUN;
               aligned_d     = 1'b1;
            end
         end
         RUN: begin
            lane_vld_d[ptr_q] = bus.valid_in;
            if (bus.valid_in) begin
               lane_buf_d[ptr_q] = bus.data_in;
            end
            ptr_d = ptr_q + PTR_W'(1);

            if (ptr_q == PTR_W'(LANES - 1)) begin
               for (int i = 0; i < LANES - 1; i++) begin
                  data_out_d[i]  = lane_buf_q[i];
                  valid_out_d[i] = lane_vld_q[i];
               end
               // Lane 3 bypasses its buffer so it lands in the same frame.
               data_out_d[LANES-1]  = bus.valid_in ? bus.data_in : lane_buf_q[LANES-1];
               valid_out_d[LANES-1] = bus.valid_in;
               frame_pulse_d        = 1'b1;

               if (!(lane_vld_q[0] | lane_vld_q[1] | lane_vld_q[2] | bus.valid_in)) begin
                  state_d   = IDLE;
                  ptr_d     = '0;
                  aligned_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         frame_pulse_q <= 1'b0;
         aligned_q     <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            lane_buf_q[i]  <= '0;
            lane_vld_q[i]  <= 1'b0;
            data_out_q[i]  <= '0;
            valid_out_q[i] <= 1'b0;
         end
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         frame_pulse_q <= frame_pulse_d;
         aligned_q     <= aligned_d;
         for (int i = 0; i < LANES; i++) begin
            lane_buf_q[i]  <= lane_buf_d[i];
            lane_vld_q[i]  <= lane_vld_d[i];
            data_out_q[i]  <= data_out_d[i];
            valid_out_q[i] <= valid_out_d[i];
         end
      end
   end

   assign bus.data_out0   = data_out_q[0];
   assign bus.data_out1   = data_out_q[1];
   assign bus.data_out2   = data_out_q[2];
   assign bus.data_out3   = data_out_q[3];
   assign bus.valid_out0  = valid_out_q[0];
   assign bus.valid_out1  = valid_out_q[1];
   assign bus.valid_out2  = valid_out_q[2];
   assign bus.valid_out3  = valid_out_q[3];
   assign bus.frame_pulse = frame_pulse_q;
   assign bus.aligned     = aligned_q;

endmodule

`default_nettype wire

// File: doc/demux_1x4.md
Name: demux_1x4

Overview:
- Receive-side counterpart of the phy_tx 4:1 byte mux; sits in phy_rx.
- Takes the single byte-wide lane stream at clk_4f, where one beat carries one lane and lanes arrive in order 0,1,2,3.
- Redistributes the stream onto four parallel byte lanes with per-lane valids.
- Publishes all four lanes together once per 4-beat frame, i.e. at the clk_f rate, while running entirely on clk_4f.

Parameters:
- DATA_WIDTH, 8, width of the input beat and of each output lane.

Ports:
- clk_4f  input  1  sole clock; fast (4x) side.
- reset  input  1  synchronous, active-low reset; 0 = reset at the next clk_4f rising edge.
- data_in  input  DATA_WIDTH  serialized lane byte.
- valid_in  input  1  data_in holds a valid byte for the current lane slot.
- data_out0..data_out3  output  DATA_WIDTH each  lane 0..3 bytes of the last completed frame.
- valid_out0..valid_out3  output  1 each  lane 0..3 valid flags of the last completed frame.
- frame_pulse  output  1  one-cycle strobe when the outputs update.
- aligned  output  1  high while in RUN.

Behaviour:
- Interface (already decided): one clock, clk_4f. Reset is synchronous and active-low, port name reset. All state changes occur only on the rising edge of clk_4f.
- While reset=0 at an edge, the following are cleared:
  - all data_outN = 0, all valid_outN = 0, frame_pulse = 0, aligned = 0;
  - lane pointer ptr = 0, state = IDLE, all gather buffers = 0.
- Reset mid-frame discards the partial frame; outputs keep no stale data.
- State machine has two states, IDLE and RUN.
- IDLE:
  - ptr held at 0.
  - The first edge with valid_in=1 is defined as lane 0. Capture data_in into buf0, set vbuf0=1, ptr<=1, state<=RUN, aligned<=1.
  - valid_in=0 edges are ignored.
- RUN: every edge, regardless of valid_in:
  - vbuf[ptr] <= valid_in.
  - buf[ptr] <= data_in only when valid_in=1; otherwise buf[ptr] keeps its value.
  - ptr <= ptr+1 mod 4; wrap from 3 to 0 with no gap cycle.
- Publish:
  - On the edge where ptr==3, the beat being captured is lane 3.
  - At that same edge, data_out0..2/valid_out0..2 are loaded from buf0..2/vbuf0..2, and data_out3/valid_out3 from data_in/valid_in directly, so the lane-3 byte is not delayed by one extra frame.
  - frame_pulse=1 for exactly the following cycle; 0 otherwise.
  - Latency: the lane-3 beat at edge N is visible on the outputs after edge N.
- Outputs hold between publishes; they change only on publish edges or reset.
- A lane whose beat had valid_in=0 publishes valid_outN=0 and data_outN equal to the last valid byte for that lane, or 0 if none since reset.
- Loss of alignment: if a published frame has all four valids = 0:
  - that frame is still published, with frame_pulse=1;
  - state<=IDLE, ptr<=0, aligned<=0 on that same edge.
- An IDLE cycle with valid_in=1 on the same edge as the reset deassertion edge is not captured, because reset dominates.
- All arithmetic is 2-bit unsigned for ptr; there is no data arithmetic.

Decomposition:
- Shared phy_rx include/package holds:
  - LANES=4 and PTR_W=2;
  - state encodings IDLE=1'b0, RUN=1'b1;
  - DATA_WIDTH default, shared with the phy_tx mux.
- Single flat module; no sub-module is warranted. The pointer counter and the gather/publish registers fit in one always block plus the next-state logic (~150 lines).

Test Plan:
- Reset check: reset=0 for 3 edges with valid_in=1, data_in=8'hAA -> all outputs 0, frame_pulse=0, aligned=0.
- Single frame: release reset, then beats EE,01,FF,FD with valid_in=1 on consecutive edges -> the cycle after FD shows data_out0..3 = EE,01,FF,FD, all valid_outN=1, frame_pulse=1 for one cycle, aligned=1.
- Back-to-back frames: beats EE,01,FF,FD,EF,02,00,FE -> frame_pulse high 1 cycle, twice, 4 cycles apart; the second publish shows EF,02,00,FE.
- Partial valid: beats EE,01,FF,FD, then XX(v=0),02,00(v=0),FE -> second frame shows valid_out = 0,1,0,1 and data_out = EE,02,FF,FE.
- Alignment loss: after one good frame, 4 beats with valid_in=0 -> publish with all valids 0 and frame_pulse=1, then aligned=0. The next valid beat 8'h55 becomes lane 0 of a new frame.
- Mid-frame reset: after lanes 0–1 of a frame, reset=0 for 1 edge, then a full frame 11,22,33,44 -> only 11,22,33,44 is published, with no mixed bytes.
